// File: rtl/sprite_frame_ctrl.sv
// sprite_frame_ctrl
// Game-loop sequencer for the obstacle-dodger VGA path. It loads the initial
// positions, draws every sprite once, then on each video frame erases all
// sprites, applies one movement step and redraws them. A finish condition
// latches game-over once any scan in flight has completed. The number of
// completed frame updates is kept as a saturating score.
//
// Ports
//   clock        system clock
//   resetn       synchronous, active-low reset
//   start        start/restart key (level)
//   frame_tick   one-cycle pulse per video frame
//   finish       player reached the end or hit an obstacle
//   ld_init      datapath loads initial positions/colour
//   ld_pos       datapath applies one movement step
//   writeEnable  pixel write strobe to the VGA adapter
//   erase        1 = write background colour, 0 = sprite colour
//   spr_sel      index of the sprite being scanned
//   off_x/off_y  pixel offset inside the sprite being scanned
//   busy         high while loading, drawing, erasing or updating
//   game_over    high once the game has ended
//   score        completed frame updates since the last start
module sprite_frame_ctrl #(
    parameter int NUM_SPRITES = 2,
    parameter int SPR_W       = 4,
    parameter int SPR_H       = 4,
    parameter int SCORE_W     = 8,
    localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int XW         = (SPR_W > 1) ? $clog2(SPR_W) : 1,
    localparam int YW         = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               finish,
    output logic               ld_init,
    output logic               ld_pos,
    output logic               writeEnable,
    output logic               erase,
    output logic [SEL_W-1:0]   spr_sel,
    output logic [XW-1:0]      off_x,
    output logic [YW-1:0]      off_y,
    output logic               busy,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NUM_SPRITES - 1);
    localparam logic [XW-1:0]      X_LAST    = XW'(SPR_W - 1);
    localparam logic [YW-1:0]      Y_LAST    = YW'(SPR_H - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SEL_W-1:0]   sel_q;
    logic [XW-1:0]      x_q;
    logic [YW-1:0]      y_q;
    logic [SCORE_W-1:0] score_q;
    logic               finish_latch;

    logic x_last;
    logic y_last;
    logic sel_last;
    logic scan_last;
    logic scanning;
    logic load_entry;
    logic finish_window;

    assign x_last    = (x_q == X_LAST);
    assign y_last    = (y_q == Y_LAST);
    assign sel_last  = (sel_q == SEL_LAST);
    assign scan_last = x_last && y_last && sel_last;
    assign scanning  = (state == S_DRAW) || (state == S_ERASE);

    // Clearing on the way into LOAD (not only while in it) means score and
    // the latch already read zero during the very first LOAD cycle.
    assign load_entry = (state_next == S_LOAD);

    // Finish is only meaningful once a game is on screen.
    assign finish_window = (state == S_DRAW) || (state == S_WAIT) ||
                           (state == S_ERASE) || (state == S_UPDATE);

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In WAIT the live finish input is also considered so
    // that finish and frame_tick arriving together end the game immediately
    // instead of starting an erase pass.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   if (!start) state_next = S_DRAW;
            S_DRAW:   if (scan_last) state_next = S_WAIT;
            S_WAIT: begin
                if (finish_latch || finish) begin
                    state_next = S_DONE;
                end else if (frame_tick) begin
                    state_next = S_ERASE;
                end
            end
            S_ERASE:  if (scan_last) state_next = S_UPDATE;
            S_UPDATE: state_next = S_DRAW;
            S_DONE:   if (start) state_next = S_LOAD;
            default:  state_next = S_IDLE;
        endcase
    end

    // Row-major pixel scanner. At the last pixel of the last sprite all three
    // counters wrap to zero together, so every pass starts at (0,0,0).
    always_ff @(posedge clock) begin
        if (!resetn || load_entry) begin
            sel_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else if (scanning) begin
            if (x_last) begin
                x_q <= '0;
                if (y_last) begin
                    y_q <= '0;
                    if (sel_last) begin
                        sel_q <= '0;
                    end else begin
                        sel_q <= sel_q + SEL_W'(1);
                    end
                end else begin
                    y_q <= y_q + YW'(1);
                end
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    // Finish latch. It is only acted upon in WAIT, which lets any scan in
    // progress finish so the screen is never left half-erased.
    always_ff @(posedge clock) begin
        if (!resetn || load_entry) begin
            finish_latch <= 1'b0;
        end else if (finish_window && finish) begin
            finish_latch <= 1'b1;
        end
    end

    // Saturating score, bumped once per movement step.
    always_ff @(posedge clock) begin
        if (!resetn || load_entry) begin
            score_q <= '0;
        end else if ((state == S_UPDATE) && (score_q != SCORE_MAX)) begin
            score_q <= score_q + SCORE_W'(1);
        end
    end

    // Output decode from registered state only.
    always_comb begin
        ld_init     = 1'b0;
        ld_pos      = 1'b0;
        writeEnable = 1'b0;
        erase       = 1'b0;
        busy        = 1'b0;
        game_over   = 1'b0;
        case (state)
            S_LOAD: begin
                ld_init = 1'b1;
                busy    = 1'b1;
            end
            S_DRAW: begin
                writeEnable = 1'b1;
                busy        = 1'b1;
            end
            S_ERASE: begin
                writeEnable = 1'b1;
                erase       = 1'b1;
                busy        = 1'b1;
            end
            S_UPDATE: begin
                ld_pos = 1'b1;
                busy   = 1'b1;
            end
            S_DONE:  game_over = 1'b1;
            default: ;
        endcase
    end

    assign spr_sel = sel_q;
    assign off_x   = x_q;
    assign off_y   = y_q;
    assign score   = score_q;

endmodule

// File: tb/tb_sprite_frame_ctrl.sv
// tb_sprite_frame_ctrl
// Checks two configurations of sprite_frame_ctrl: the default one (2 sprites
// of 4x4, 8-bit score) and a degenerate one (3 sprites of 1x2, 2-bit score).
// Both instances share the inputs; use_b selects which one is observed and
// the model parameters are switched to match. Expected values come from a
// small model: pixel k of a pass maps to sprite k/(W*H), row (k/W)%H,
// column k%W, and the score is min(frames, 2^SCORE_W-1).
module tb_sprite_frame_ctrl;

    logic clock = 1'b0;
    logic resetn;
    logic start;
    logic frame_tick;
    logic finish;

    logic       a_ld_init, a_ld_pos, a_we, a_erase, a_busy, a_go;
    logic [0:0] a_sel;
    logic [1:0] a_x;
    logic [1:0] a_y;
    logic [7:0] a_score;

    logic       b_ld_init, b_ld_pos, b_we, b_erase, b_busy, b_go;
    logic [1:0] b_sel;
    logic [0:0] b_x;
    logic [0:0] b_y;
    logic [1:0] b_score;

    bit use_b = 1'b0;

    int obs_ld_init, obs_ld_pos, obs_we, obs_erase, obs_busy, obs_go;
    int obs_sel, obs_x, obs_y, obs_score;

    int p_n, p_w, p_h, p_smax, p_len;
    int model_score;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    sprite_frame_ctrl #(
        .NUM_SPRITES(2), .SPR_W(4), .SPR_H(4), .SCORE_W(8)
    ) dut_a (
        .clock(clock), .resetn(resetn), .start(start),
        .frame_tick(frame_tick), .finish(finish),
        .ld_init(a_ld_init), .ld_pos(a_ld_pos), .writeEnable(a_we),
        .erase(a_erase), .spr_sel(a_sel), .off_x(a_x), .off_y(a_y),
        .busy(a_busy), .game_over(a_go), .score(a_score)
    );

    sprite_frame_ctrl #(
        .NUM_SPRITES(3), .SPR_W(1), .SPR_H(2), .SCORE_W(2)
    ) dut_b (
        .clock(clock), .resetn(resetn), .start(start),
        .frame_tick(frame_tick), .finish(finish),
        .ld_init(b_ld_init), .ld_pos(b_ld_pos), .writeEnable(b_we),
        .erase(b_erase), .spr_sel(b_sel), .off_x(b_x), .off_y(b_y),
        .busy(b_busy), .game_over(b_go), .score(b_score)
    );

    // Route the selected instance onto a common set of observation points.
    always_comb begin
        if (use_b) begin
            obs_ld_init = int'(b_ld_init);
            obs_ld_pos  = int'(b_ld_pos);
            obs_we      = int'(b_we);
            obs_erase   = int'(b_erase);
            obs_busy    = int'(b_busy);
            obs_go      = int'(b_go);
            obs_sel     = int'(b_sel);
            obs_x       = int'(b_x);
            obs_y       = int'(b_y);
            obs_score   = int'(b_score);
        end else begin
            obs_ld_init = int'(a_ld_init);
            obs_ld_pos  = int'(a_ld_pos);
            obs_we      = int'(a_we);
            obs_erase   = int'(a_erase);
            obs_busy    = int'(a_busy);
            obs_go      = int'(a_go);
            obs_sel     = int'(a_sel);
            obs_x       = int'(a_x);
            obs_y       = int'(a_y);
            obs_score   = int'(a_score);
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit ft, input bit fin);
        start      = s;
        frame_tick = ft;
        finish     = fin;
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic set_config(input bit b);
        use_b = b;
        if (b) begin
            p_n = 3; p_w = 1; p_h = 2; p_smax = 3;
        end else begin
            p_n = 2; p_w = 4; p_h = 4; p_smax = 255;
        end
        p_len = p_n * p_w * p_h;
    endtask

    task automatic check_zero(input string tag);
        checkOutput({tag, "_we"},      obs_we,      0);
        checkOutput({tag, "_erase"},   obs_erase,   0);
        checkOutput({tag, "_ld_init"}, obs_ld_init, 0);
        checkOutput({tag, "_ld_pos"},  obs_ld_pos,  0);
        checkOutput({tag, "_busy"},    obs_busy,    0);
        checkOutput({tag, "_go"},      obs_go,      0);
        checkOutput({tag, "_sel"},     obs_sel,     0);
        checkOutput({tag, "_x"},       obs_x,       0);
        checkOutput({tag, "_y"},       obs_y,       0);
        checkOutput({tag, "_score"},   obs_score,   0);
    endtask

    task automatic check_wait();
        checkOutput("wait_we",     obs_we,     0);
        checkOutput("wait_busy",   obs_busy,   0);
        checkOutput("wait_go",     obs_go,     0);
        checkOutput("wait_ld_pos", obs_ld_pos, 0);
        checkOutput("wait_score",  obs_score,  model_score);
    endtask

    task automatic check_done();
        checkOutput("done_go",    obs_go,    1);
        checkOutput("done_we",    obs_we,    0);
        checkOutput("done_busy",  obs_busy,  0);
        checkOutput("done_score", obs_score, model_score);
    endtask

    // Hold start for h cycles from IDLE or DONE, then release it; returns at
    // the first pixel of the initial draw.
    task automatic do_start(input int h);
        for (int i = 0; i < h; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            next_cycle();
            checkOutput("load_ld_init", obs_ld_init, 1);
            checkOutput("load_busy",    obs_busy,    1);
            checkOutput("load_go",      obs_go,      0);
            checkOutput("load_score",   obs_score,   0);
        end
        model_score = 0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        next_cycle();
    endtask

    // Walk one full pass. fin_at/tick_at pulse finish/frame_tick at that pixel;
    // rst_at asserts reset at that pixel and abandons the pass.
    task automatic check_scan(input int er, input int fin_at, input int tick_at,
                              input int rst_at);
        for (int k = 0; k < p_len; k++) begin
            checkOutput("scan_we",    obs_we,    1);
            checkOutput("scan_erase", obs_erase, er);
            checkOutput("scan_busy",  obs_busy,  1);
            checkOutput("scan_sel",   obs_sel,   k / (p_w * p_h));
            checkOutput("scan_y",     obs_y,     (k / p_w) % p_h);
            checkOutput("scan_x",     obs_x,     k % p_w);
            if (k == 0) checkOutput("scan_score", obs_score, model_score);
            if (k == rst_at) begin
                resetn = 1'b0;
                applyStimulus(1'b0, 1'b0, 1'b0);
                next_cycle();
                model_score = 0;
                return;
            end
            applyStimulus(1'b0, k == tick_at, k == fin_at);
            next_cycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_update();
        checkOutput("upd_ld_pos", obs_ld_pos, 1);
        checkOutput("upd_we",     obs_we,     0);
        checkOutput("upd_busy",   obs_busy,   1);
        next_cycle();
        model_score = (model_score + 1 > p_smax) ? p_smax : model_score + 1;
    endtask

    // One frame from WAIT: idle a little, tick, erase, update, redraw.
    task automatic run_frame(input int fin_e, input int tick_e, input int fin_d);
        int idle;
        idle = int'($urandom_range(0, 3));
        for (int i = 0; i < idle; i++) begin
            check_wait();
            applyStimulus(1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        check_scan(1, fin_e, tick_e, -1);
        check_update();
        check_scan(0, fin_d, -1, -1);
        check_wait();
        if (fin_e >= 0 || fin_d >= 0) begin
            next_cycle();
            check_done();
        end
    endtask

    // Frame ticks in DONE must not restart scanning.
    task automatic idle_in_done(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            next_cycle();
            check_done();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        set_config(1'b0);
        model_score = 0;
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        check_zero("reset_a");

        resetn = 1'b1;
        do_start(3);
        check_scan(0, -1, -1, -1);
        check_wait();

        // First frame with a dropped tick somewhere inside the erase pass.
        run_frame(-1, int'($urandom_range(1, p_len - 2)), -1);
        checkOutput("score_after_first", obs_score, 1);
        for (int f = 0; f < 3; f++) run_frame(-1, -1, -1);

        // Finish during the redraw at pixel 10.
        run_frame(-1, -1, 10);
        idle_in_done(3);
        do_start(1);
        check_scan(0, -1, -1, -1);
        check_wait();

        // Finish and frame_tick together in WAIT.
        applyStimulus(1'b0, 1'b1, 1'b1);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        check_done();
        next_cycle();
        check_done();
        do_start(int'($urandom_range(1, 3)));
        check_scan(0, -1, -1, -1);
        check_wait();

        // Finish at a random erase pixel still completes update and redraw.
        run_frame(int'($urandom_range(0, p_len - 1)), -1, -1);
        idle_in_done(2);
        do_start(2);
        check_scan(0, -1, -1, -1);
        check_wait();
        run_frame(-1, -1, -1);

        // Reset in the middle of an erase pass.
        applyStimulus(1'b0, 1'b1, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        check_scan(1, -1, -1, 7);
        check_zero("rst_erase_a");
        resetn = 1'b1;
        next_cycle();
        check_zero("idle_after_rst_a");

        // Degenerate configuration with a 2-bit score.
        set_config(1'b1);
        resetn = 1'b0;
        next_cycle();
        next_cycle();
        check_zero("reset_b");
        resetn = 1'b1;
        do_start(int'($urandom_range(1, 4)));
        check_scan(0, -1, -1, -1);
        check_wait();
        for (int f = 0; f < 5; f++) begin
            run_frame(-1, -1, -1);
            checkOutput("b_score_seq", obs_score, (f + 1 > 3) ? 3 : f + 1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        check_scan(1, -1, -1, int'($urandom_range(0, p_len - 1)));
        check_zero("rst_erase_b");
        resetn = 1'b1;
        do_start(1);
        check_scan(0, -1, -1, -1);
        check_wait();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
